// File: rtl/core2wb_if.sv
// core2wb_if.sv
// Bus interfaces for the core2wb bridge.
//
//   core2wb_core_if : core-side request/response channel
//     master modport -> the processor core (issues requests, receives responses)
//     slave  modport -> the bridge
//   core2wb_wb_if   : Wishbone B4 pipelined channel
//     master modport -> the bridge
//     slave  modport -> the Wishbone target
//
// Both interfaces only group the signals; they carry no logic.

interface core2wb_core_if;
  logic        core_req;
  logic        core_gnt;
  logic        core_rvalid;
  logic        core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_err;

  modport master (
    output core_req, core_we, core_be, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata, core_err
  );

  modport slave (
    input  core_req, core_we, core_be, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata, core_err
  );
endinterface

interface core2wb_wb_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );
endinterface

// File: rtl/core2wb.sv
// core2wb.sv
// Bridge from a simple req/gnt/rvalid core bus to a Wishbone B4 pipelined
// master. Requests pass straight through to the bus; a request is granted in
// the cycle Wishbone accepts it. Responses come back in issue order through
// a single response register (one cycle latency).
//
// Parameters
//   MAX_OUTSTANDING : granted-but-unanswered transfers allowed (1..7)
//   TIMEOUT         : response watchdog limit in cycles (1..65535)
//
// Ports
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous, active-high reset
//   core : core2wb_core_if.slave (core_req/gnt/rvalid/we/be/addr/wdata/rdata/err)
//   wb   : core2wb_wb_if.master  (wb_cyc/stb/we/sel/adr/dat_o, wb_dat/ack/err/stall_i)
//
// Optional feature macro: CORE2WB_TIMEOUT_EN
//   Defined   : a watchdog counts cycles spent waiting in ACTIVE without a
//               response; on reaching TIMEOUT the bridge enters ABORT, drops
//               the bus cycle and answers every outstanding transfer with an
//               error response, one per cycle.
//   Undefined : no watchdog and no ABORT state; ACTIVE waits indefinitely.

module core2wb #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT         = 255
) (
  input  logic             clk,
  input  logic             rst,
  core2wb_core_if.slave    core,
  core2wb_wb_if.master     wb
);

  // Reject illegal configurations at elaboration time.
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7) begin : g_bad_max
    $error("core2wb: MAX_OUTSTANDING must be 1..7");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("core2wb: TIMEOUT must be 1..65535");
  end

  localparam logic [2:0] LP_MAX = 3'(MAX_OUTSTANDING);

`ifdef CORE2WB_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ABORT  = 2'd2
  } state_t;
  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);
  logic [15:0] r_wd;
`else
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;
`endif

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_abort;
  logic        w_stb;
  logic        w_gnt;
  logic        w_resp;
  logic [2:0]  w_cnt_nxt;

`ifdef CORE2WB_TIMEOUT_EN
  assign w_abort = (r_state == ST_ABORT);
`else
  assign w_abort = 1'b0;
`endif

  // The grant decision looks only at the registered count, so a response in
  // the same cycle never frees a slot until the following cycle.
  // Gating with rst keeps the bus quiet while reset is held.
  assign w_stb  = core.core_req & (r_cnt < LP_MAX) & ~w_abort & ~rst;
  assign w_gnt  = w_stb & ~wb.wb_stall_i;
  // Responses with nothing outstanding, or during ABORT, are ignored.
  assign w_resp = (wb.wb_ack_i | wb.wb_err_i) & (r_cnt != 3'd0) & ~w_abort;

  assign wb.wb_stb_o = w_stb;
  assign wb.wb_cyc_o = (w_stb | (r_cnt != 3'd0)) & ~w_abort & ~rst;
  assign wb.wb_we_o  = core.core_we;
  assign wb.wb_sel_o = core.core_be;
  assign wb.wb_adr_o = core.core_addr;
  assign wb.wb_dat_o = core.core_wdata;

  assign core.core_gnt    = w_gnt;
  assign core.core_rvalid = r_rvalid;
  assign core.core_rdata  = r_rdata;
  assign core.core_err    = r_err;

  // Next outstanding count: grant and response in the same cycle cancel.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_gnt && !w_resp) begin
      w_cnt_nxt = r_cnt + 3'd1;
    end else if (!w_gnt && w_resp) begin
      w_cnt_nxt = r_cnt - 3'd1;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Control FSM, outstanding counter, watchdog and response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
`ifdef CORE2WB_TIMEOUT_EN
      r_wd     <= 16'd0;
`endif
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ACTIVE: begin
          if (w_resp) begin
            r_rvalid <= 1'b1;
            r_rdata  <= wb.wb_dat_i;
            // ack and err together count as a single error response
            r_err    <= wb.wb_err_i;
          end else begin
            r_rvalid <= 1'b0;
          end
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == 3'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_ACTIVE;
          end
`ifdef CORE2WB_TIMEOUT_EN
          // A timeout overrides the IDLE/ACTIVE choice above.
          if (r_state == ST_ACTIVE && !w_resp) begin
            if (r_wd + 16'd1 == LP_TIMEOUT) begin
              r_wd    <= 16'd0;
              r_state <= ST_ABORT;
            end else begin
              r_wd <= r_wd + 16'd1;
            end
          end else begin
            r_wd <= 16'd0;
          end
`endif
        end
`ifdef CORE2WB_TIMEOUT_EN
        // Flush: one error response per outstanding transfer, one per cycle.
        // ABORT is only entered from ACTIVE, so r_cnt is at least 1 here.
        ST_ABORT: begin
          r_rvalid <= 1'b1;
          r_rdata  <= 32'd0;
          r_err    <= 1'b1;
          r_cnt    <= r_cnt - 3'd1;
          r_wd     <= 16'd0;
          if (r_cnt == 3'd1) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_ABORT;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core2wb.sv
// tb_core2wb.sv
// Self-checking bench for core2wb. Inputs change on the falling edge; all
// outputs are compared 1 ns later against a transaction-level model that
// keeps the outstanding transfers in a queue.

module tb_core2wb;

  localparam int MAXO = 2;
  localparam int TMO  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core2wb_core_if core ();
  core2wb_wb_if   wb ();

  core2wb #(.MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core),
    .wb   (wb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] pend[$];     // addresses of granted, unanswered transfers
  logic        m_abort;
  int          m_wd;
  logic        exp_rvalid;
  logic [31:0] exp_rdata;
  logic        exp_err;

  // Last observed outputs, for directed checks
  logic        obs_gnt, obs_stb, obs_rvalid, obs_err;
  logic [31:0] obs_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check all outputs, advance the model.
  task automatic step(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic stall, input logic ack, input logic err,
                      input logic [31:0] dat);
    logic e_stb, e_gnt, e_cyc, resp;
    @(negedge clk);
    core.core_req   = req;
    core.core_we    = we;
    core.core_be    = be;
    core.core_addr  = addr;
    core.core_wdata = wdata;
    wb.wb_stall_i   = stall;
    wb.wb_ack_i     = ack;
    wb.wb_err_i     = err;
    wb.wb_dat_i     = dat;
    #1;
    e_stb = req && (pend.size() < MAXO) && !m_abort;
    e_gnt = e_stb && !stall;
    e_cyc = (e_stb || pend.size() != 0) && !m_abort;
    chk("stb",    wb.wb_stb_o,      e_stb);
    chk("gnt",    core.core_gnt,    e_gnt);
    chk("cyc",    wb.wb_cyc_o,      e_cyc);
    chk("we",     wb.wb_we_o,       we);
    chk("sel",    wb.wb_sel_o,      be);
    chk("adr",    wb.wb_adr_o,      addr);
    chk("dat_o",  wb.wb_dat_o,      wdata);
    chk("rvalid", core.core_rvalid, exp_rvalid);
    chk("rdata",  core.core_rdata,  exp_rdata);
    chk("err",    core.core_err,    exp_err);
    obs_gnt    = core.core_gnt;
    obs_stb    = wb.wb_stb_o;
    obs_rvalid = core.core_rvalid;
    obs_rdata  = core.core_rdata;
    obs_err    = core.core_err;

    // Model update for the coming rising edge
    if (m_abort) begin
      exp_rvalid = 1'b1;
      exp_err    = 1'b1;
      exp_rdata  = 32'd0;
      void'(pend.pop_front());
      if (pend.size() == 0) m_abort = 1'b0;
    end else begin
      resp = (ack || err) && pend.size() != 0;
`ifdef CORE2WB_TIMEOUT_EN
      if (pend.size() != 0 && !resp) begin
        m_wd++;
      end else begin
        m_wd = 0;
      end
`endif
      exp_rvalid = resp;
      if (resp) begin
        exp_rdata = dat;
        exp_err   = err;
        void'(pend.pop_front());
      end
      if (e_gnt) pend.push_back(addr);
`ifdef CORE2WB_TIMEOUT_EN
      if (m_wd == TMO) begin
        m_wd    = 0;
        m_abort = 1'b1;
      end
`endif
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic stall);
    step(1'b1, 1'b0, 4'hF, addr, 32'd0, stall, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic ack(input logic [31:0] dat, input logic err);
    step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, err, dat);
  endtask

  // Asynchronous reset pulse; outputs must drop within the same cycle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    core.core_req = 1'b1;
    #1;
    chk("rst_stb",    wb.wb_stb_o,      1'b0);
    chk("rst_gnt",    core.core_gnt,    1'b0);
    chk("rst_cyc",    wb.wb_cyc_o,      1'b0);
    chk("rst_rvalid", core.core_rvalid, 1'b0);
    chk("rst_rdata",  core.core_rdata,  32'd0);
    chk("rst_err",    core.core_err,    1'b0);
    pend.delete();
    m_abort    = 1'b0;
    m_wd       = 0;
    exp_rvalid = 1'b0;
    exp_rdata  = 32'd0;
    exp_err    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    core.core_req = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    core.core_req   = 1'b0;
    core.core_we    = 1'b0;
    core.core_be    = 4'h0;
    core.core_addr  = 32'd0;
    core.core_wdata = 32'd0;
    wb.wb_dat_i     = 32'd0;
    wb.wb_ack_i     = 1'b0;
    wb.wb_err_i     = 1'b0;
    wb.wb_stall_i   = 1'b0;
    do_reset();

    // Single read
    rd(32'h1000_0004, 1'b0);
    chk("rd_gnt", obs_gnt, 1'b1);
    ack(32'hDEAD_BEEF, 1'b0);
    chk("rd_rvalid_early", obs_rvalid, 1'b0);
    idle();
    chk("rd_rvalid", obs_rvalid, 1'b1);
    chk("rd_rdata",  obs_rdata,  32'hDEAD_BEEF);
    chk("rd_err",    obs_err,    1'b0);
    idle();
    chk("rd_rvalid_pulse", obs_rvalid, 1'b0);
    chk("rd_hold",         obs_rdata,  32'hDEAD_BEEF);

    // Back-to-back writes against the outstanding limit
    step(1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("b2b_gnt1", obs_gnt, 1'b1);
    step(1'b1, 1'b1, 4'h3, 32'h0000_0104, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("b2b_gnt2", obs_gnt, 1'b1);
    step(1'b1, 1'b1, 4'hC, 32'h0000_0108, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("b2b_gnt3_held", obs_gnt, 1'b0);
    chk("b2b_stb3_held", obs_stb, 1'b0);
    step(1'b1, 1'b1, 4'hC, 32'h0000_0108, 32'h3333_3333, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("b2b_gnt_same_cycle_ack", obs_gnt, 1'b0);
    step(1'b1, 1'b1, 4'hC, 32'h0000_0108, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("b2b_gnt3", obs_gnt, 1'b1);
    ack(32'd0, 1'b0);
    ack(32'd0, 1'b0);
    idle();
    idle();

    // Stall for three cycles
    for (int i = 0; i < 3; i++) begin
      rd(32'h2000_0000, 1'b1);
      chk("stall_stb", obs_stb, 1'b1);
      chk("stall_gnt", obs_gnt, 1'b0);
    end
    rd(32'h2000_0000, 1'b0);
    chk("stall_gnt4", obs_gnt, 1'b1);
    ack(32'h5555_AAAA, 1'b0);
    idle();

    // Error response with ack and err together, then a spurious ack
    rd(32'h3000_0000, 1'b0);
    step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0BAD_0BAD);
    idle();
    chk("err_rvalid", obs_rvalid, 1'b1);
    chk("err_flag",   obs_err,    1'b1);
    ack(32'h1234_5678, 1'b0);
    idle();
    chk("spurious_rvalid", obs_rvalid, 1'b0);
    chk("spurious_hold",   obs_rdata,  32'h0BAD_0BAD);

    // Reset with a transfer outstanding
    rd(32'h4000_0000, 1'b0);
    do_reset();
    ack(32'h7777_7777, 1'b0);
    idle();
    chk("post_rst_rvalid", obs_rvalid, 1'b0);
    rd(32'h4000_0010, 1'b0);
    chk("post_rst_gnt", obs_gnt, 1'b1);
    ack(32'h8888_8888, 1'b0);
    idle();
    chk("post_rst_rdata", obs_rdata, 32'h8888_8888);

`ifdef CORE2WB_TIMEOUT_EN
    // Timeout: two transfers never answered, flushed with error responses
    rd(32'h5000_0000, 1'b0);
    rd(32'h5000_0004, 1'b0);
    for (int i = 0; i < TMO + 4; i++) idle();
    chk("tmo_err", obs_err, 1'b1);
    rd(32'h5000_0008, 1'b0);
    chk("tmo_regrant", obs_gnt, 1'b1);
    ack(32'h0, 1'b0);
    idle();
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           $urandom(), $urandom(),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           $urandom());
      if (i == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
